ptmch_trg_multi: RTL and testbench
==================================

Name: ptmch_trg_multi

Overview:
Parametrised multi-channel SPI command trigger generator. It passively snoops an SPI flash bus (CS active-low, mode 0/3, sampled on SCK rising) in the CLK160M domain. It decodes each frame's opcode plus address and fires a programmable-width trigger pulse on every enabled channel whose opcode (masked) and address window match. It sits between the board SPI snoop pins and the trigger/scope outputs, and adds per-channel hit counters, frame-abort detection and retrigger handling.

Parameters:
NUM_CH, 8, number of trigger channels
OPC_W, 8, opcode width in bits
ADDR_W, 24, address width following the opcode
PW_W, 8, pulse-width register width
CNT_W, 16, per-channel hit counter width

Ports:
CLK160M  in  1  system clock, 160 MHz
RESET  in  1  synchronous reset, active-high
SPI_CS  in  1  snooped chip select, active-low, asynchronous
SPI_CLK  in  1  snooped SCK, asynchronous
SPI_MOSI  in  1  snooped MOSI, asynchronous
CH_EN  in  NUM_CH  per-channel enable
CH_OPC  in  NUM_CH*OPC_W  per-channel opcode; channel i at [i*OPC_W +: OPC_W]
CH_OPC_MASK  in  NUM_CH*OPC_W  1 = bit compared, 0 = don't care
CH_LOW_ADDR  in  NUM_CH*ADDR_W  inclusive lower address bound
CH_HIGH_ADDR  in  NUM_CH*ADDR_W  inclusive upper address bound
PLS_WIDTH  in  PW_W  trigger pulse length in CLK160M cycles; 0 is treated as 1
CNT_CLR  in  1  synchronous clear of all hit counters
TRG_PLS  out  NUM_CH  trigger pulses
HIT_CNT  out  NUM_CH*CNT_W  saturating per-channel hit counters
FRM_VLD  out  1  1-cycle strobe when a complete frame is compared
FRM_WORD  out  OPC_W+ADDR_W  last complete frame, held until next FRM_VLD
FRM_ABORT  out  1  1-cycle strobe when CS rises before FRAME_BITS bits are received

Behaviour:
- One clock (CLK160M). RESET is synchronous, active-high. All flops are cleared in the cycle RESET is sampled high.
- Reset values: TRG_PLS=0, HIT_CNT=0, FRM_VLD=0, FRM_WORD=0, FRM_ABORT=0, state=IDLE. Sync flops reset to CS=1, SCK=0, MOSI=0.
- Synchroniser: each SPI input goes through a 2-flop synchroniser plus 1 history flop.
  - SCK rise = sync2 & ~hist.
  - CS fall = ~cs_sync2 & cs_hist; CS rise = cs_sync2 & ~cs_hist.
- Requirement on SPI timing: SCK high and low phases ≥ 3 CLK160M cycles each (SCK ≤ 26 MHz).
- FRAME_BITS = OPC_W+ADDR_W. Frame word layout: opcode in the MSBs, address MSB-first.
- FSM states: IDLE, SHIFT, CMP, HOLD.
  - IDLE: on CS fall → SHIFT, with shift register and bit counter cleared.
  - SHIFT: each SCK rise shifts MOSI in at the LSB and increments the counter. The cycle the FRAME_BITS-th bit is captured (cycle C) → CMP. CS rise before that → FRM_ABORT=1 for one cycle, then → IDLE, with no compare.
  - CMP (cycle C+1):
    - Channel i matches when CH_EN[i] is set, and ((opc ^ CH_OPC_i) & CH_OPC_MASK_i)==0, and LOW_i ≤ addr ≤ HIGH_i (unsigned).
    - Config inputs are sampled in this cycle only.
    - FRM_VLD=1 and FRM_WORD is updated in this cycle.
    - Next state: HOLD.
  - HOLD: further SCK edges are ignored (data phase). CS rise → IDLE.
- A CS fall while in CMP or HOLD without an intervening CS rise cannot occur, since edges alternate. A CS fall seen in IDLE always starts a new frame.
- Trigger pulse:
  - Matching channels assert TRG_PLS from cycle C+2 for max(PLS_WIDTH,1) cycles. A single shared down-counter plus a latched match vector drive this.
  - Retrigger: a new CMP match while the pulse is active reloads the counter and ORs in the new match vector. A CMP with no match does not cut an active pulse.
  - A CS rise does not truncate a pulse in progress.
- A channel with LOW > HIGH never matches.
- Hit counters:
  - Increment in cycle C+2 for each matching channel.
  - Saturate at all-ones.
  - CNT_CLR takes priority over a simultaneous increment (result 0).
- RESET mid-frame or mid-pulse: outputs clear immediately; the next frame is recognised only after a fresh CS fall.

Decomposition:
- Package ptmch_trg_pkg:
  - state enum t_trg_state {IDLE, SHIFT, CMP, HOLD}.
  - Default opcode constants: PROGRAM_EXECUTE 8'h10, READ_STATUS1 8'h0F, READ_STATUS2 8'h05, BLOCK_ERASE_128K 8'hD8, PAGE_DATA_READ 8'h13, WRITE_STATUS1 8'h1F, WRITE_STATUS2 8'h01.
- Sub-module ptmch_spi_sniffer: synchronisers, edge detects, shift register and bit counter. It outputs bit_vld, frame_done, frame_abort and frame_word.
- Top level: FSM, per-channel compare generate loop, pulse timer, counters.

Test Plan:
1. Ch0 set to OPC=8'h10, mask 8'hFF, window 0x000100–0x0001FF, PLS_WIDTH=16; frame 0x10_000150 → TRG_PLS[0] high exactly 16 cycles starting C+2; HIT_CNT0=1; FRM_WORD=32'h10000150.
2. Same config; frames 0x10_0000FF and 0x10_000200 → no pulse, FRM_VLD strobes twice. Frames with addresses 0x000100 and 0x0001FF → pulses (inclusive boundaries).
3. Ch1 OPC=8'h0F with mask 8'hF0 (matches 0x0*); frame 0x05_000000 → TRG_PLS[1]. Same frame with CH_EN[1]=0 → no pulse.
4. CS raised after 20 bits → FRM_ABORT one cycle, no FRM_VLD, no pulse. The following full frame 0xD8_123456 with ch2 window 0–0xFFFFFF → TRG_PLS[2].
5. PLS_WIDTH=40; second matching frame arrives 30 cycles into the pulse → pulse stays continuously high until 40 cycles after the second C+2. PLS_WIDTH=0 → 1-cycle pulse.
6. CNT_W=4 build: 17 matching frames → HIT_CNT saturates at 15. CNT_CLR asserted in the same cycle as a hit → 0. RESET mid-pulse → TRG_PLS=0 next cycle.

Source files
------------

// File: rtl/ptmch_trg_pkg.sv
// Shared types and constants for the SPI command trigger generator.
package ptmch_trg_pkg;

    // Frame tracking states of the trigger FSM
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CMP   = 2'd2,
        HOLD  = 2'd3
    } t_trg_state;

    // Default flash opcodes commonly programmed into the channel registers
    localparam logic [7:0] PROGRAM_EXECUTE  = 8'h10;
    localparam logic [7:0] READ_STATUS1     = 8'h0F;
    localparam logic [7:0] READ_STATUS2     = 8'h05;
    localparam logic [7:0] BLOCK_ERASE_128K = 8'hD8;
    localparam logic [7:0] PAGE_DATA_READ   = 8'h13;
    localparam logic [7:0] WRITE_STATUS1    = 8'h1F;
    localparam logic [7:0] WRITE_STATUS2    = 8'h01;

endpackage

// File: rtl/ptmch_spi_sniffer.sv
// Passive SPI bus snooper: synchronises CS/SCK/MOSI into the system clock,
// detects edges and assembles the opcode+address word MSB-first.
module ptmch_spi_sniffer
    import ptmch_trg_pkg::*;
#(
    parameter int FRAME_BITS = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_spi_cs,
    input  logic                  i_spi_clk,
    input  logic                  i_spi_mosi,
    input  logic                  i_clr,
    input  logic                  i_shift_en,
    output logic                  o_cs_fall,
    output logic                  o_cs_rise,
    output logic                  o_bit_vld,
    output logic                  o_frame_done,
    output logic                  o_frame_abort,
    output logic [FRAME_BITS-1:0] o_frame_word
);

    localparam int CNT_BITS = $clog2(FRAME_BITS + 1);

    logic r_cs_s1, r_cs_s2, r_cs_h;
    logic r_sck_s1, r_sck_s2, r_sck_h;
    logic r_mosi_s1, r_mosi_s2, r_mosi_h;

    logic [FRAME_BITS-1:0] r_shreg;
    logic [CNT_BITS-1:0]   r_bit_cnt;

    logic w_sck_rise;

    // Two-flop synchronisers plus one history flop per snooped line
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_h    <= 1'b1;
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_h   <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_mosi_h  <= 1'b0;
        end else begin
            r_cs_s1   <= i_spi_cs;
            r_cs_s2   <= r_cs_s1;
            r_cs_h    <= r_cs_s2;
            r_sck_s1  <= i_spi_clk;
            r_sck_s2  <= r_sck_s1;
            r_sck_h   <= r_sck_s2;
            r_mosi_s1 <= i_spi_mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_mosi_h  <= r_mosi_s2;
        end
    end

    assign w_sck_rise    = r_sck_s2 & ~r_sck_h;
    assign o_cs_fall     = ~r_cs_s2 & r_cs_h;
    assign o_cs_rise     = r_cs_s2 & ~r_cs_h;
    assign o_bit_vld     = i_shift_en & w_sck_rise;
    assign o_frame_done  = o_bit_vld & (r_bit_cnt == CNT_BITS'(FRAME_BITS - 1));
    assign o_frame_abort = i_shift_en & o_cs_rise & ~o_frame_done;
    assign o_frame_word  = r_shreg;

    // Shift register and bit counter; MOSI is taken from the history flop,
    // which is one cycle older than the SCK edge and well inside the
    // stable window of a mode 0/3 bus.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (i_clr) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (o_bit_vld) begin
            r_shreg   <= {r_shreg[FRAME_BITS-2:0], r_mosi_h};
            r_bit_cnt <= r_bit_cnt + CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/ptmch_trg_multi.sv
// Multi-channel SPI command trigger: decodes opcode+address frames snooped
// from a flash bus and fires per-channel trigger pulses with hit counting.
module ptmch_trg_multi
    import ptmch_trg_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int OPC_W  = 8,
    parameter int ADDR_W = 24,
    parameter int PW_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       CLK160M,
    input  logic                       RESET,
    input  logic                       SPI_CS,
    input  logic                       SPI_CLK,
    input  logic                       SPI_MOSI,
    input  logic [NUM_CH-1:0]          CH_EN,
    input  logic [NUM_CH*OPC_W-1:0]    CH_OPC,
    input  logic [NUM_CH*OPC_W-1:0]    CH_OPC_MASK,
    input  logic [NUM_CH*ADDR_W-1:0]   CH_LOW_ADDR,
    input  logic [NUM_CH*ADDR_W-1:0]   CH_HIGH_ADDR,
    input  logic [PW_W-1:0]            PLS_WIDTH,
    input  logic                       CNT_CLR,
    output logic [NUM_CH-1:0]          TRG_PLS,
    output logic [NUM_CH*CNT_W-1:0]    HIT_CNT,
    output logic                       FRM_VLD,
    output logic [OPC_W+ADDR_W-1:0]    FRM_WORD,
    output logic                       FRM_ABORT
);

    localparam int FRAME_BITS = OPC_W + ADDR_W;

    t_trg_state r_state, w_state_nxt;

    logic w_cs_fall, w_cs_rise, w_bit_vld, w_frame_done, w_frame_abort;
    logic w_sniff_clr, w_shift_en;
    logic [FRAME_BITS-1:0] w_frame_word;
    logic [OPC_W-1:0]      w_opc;
    logic [ADDR_W-1:0]     w_addr;
    logic [NUM_CH-1:0]     w_match;
    logic [NUM_CH-1:0]     w_hit;

    logic [FRAME_BITS-1:0] r_frm_word;
    logic                  r_frm_abort;
    logic [PW_W-1:0]       r_pls_cnt;
    logic [NUM_CH-1:0]     r_pls_vec;
    logic [CNT_W-1:0]      r_hit_cnt [NUM_CH];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [PW_W-1:0] pls_len(input logic [PW_W-1:0] w);
        return (w == '0) ? PW_W'(1) : w;
    endfunction

    ptmch_spi_sniffer #(
        .FRAME_BITS (FRAME_BITS)
    ) u_sniffer (
        .i_clk         (CLK160M),
        .i_rst         (RESET),
        .i_spi_cs      (SPI_CS),
        .i_spi_clk     (SPI_CLK),
        .i_spi_mosi    (SPI_MOSI),
        .i_clr         (w_sniff_clr),
        .i_shift_en    (w_shift_en),
        .o_cs_fall     (w_cs_fall),
        .o_cs_rise     (w_cs_rise),
        .o_bit_vld     (w_bit_vld),
        .o_frame_done  (w_frame_done),
        .o_frame_abort (w_frame_abort),
        .o_frame_word  (w_frame_word)
    );

    // Frame FSM state register
    always_ff @(posedge CLK160M) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic and sniffer control
    always_comb begin
        w_state_nxt = r_state;
        w_sniff_clr = 1'b0;
        w_shift_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_sniff_clr = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_shift_en = 1'b1;
                if (w_bit_vld && w_frame_done) w_state_nxt = CMP;
                else if (w_frame_abort)        w_state_nxt = IDLE;
            end
            // A CS rise landing exactly on the compare cycle must not be lost
            CMP:     w_state_nxt = w_cs_rise ? IDLE : HOLD;
            HOLD:    if (w_cs_rise) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_opc  = w_frame_word[FRAME_BITS-1 -: OPC_W];
    assign w_addr = w_frame_word[ADDR_W-1:0];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [OPC_W-1:0]  w_ch_opc, w_ch_mask;
        logic [ADDR_W-1:0] w_ch_lo, w_ch_hi;
        assign w_ch_opc  = CH_OPC[gi*OPC_W +: OPC_W];
        assign w_ch_mask = CH_OPC_MASK[gi*OPC_W +: OPC_W];
        assign w_ch_lo   = CH_LOW_ADDR[gi*ADDR_W +: ADDR_W];
        assign w_ch_hi   = CH_HIGH_ADDR[gi*ADDR_W +: ADDR_W];
        // An inverted window (LOW > HIGH) fails one of the bounds by construction
        assign w_match[gi] = CH_EN[gi]
                           & (((w_opc ^ w_ch_opc) & w_ch_mask) == '0)
                           & (w_addr >= w_ch_lo)
                           & (w_addr <= w_ch_hi);
        assign HIT_CNT[gi*CNT_W +: CNT_W] = r_hit_cnt[gi];
    end

    // Config is only looked at during the compare cycle
    assign w_hit = (r_state == CMP) ? w_match : '0;

    // Latch the compared frame so it stays visible until the next one
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            r_frm_word  <= '0;
            r_frm_abort <= 1'b0;
        end else begin
            r_frm_abort <= w_frame_abort;
            if (r_state == CMP) r_frm_word <= w_frame_word;
        end
    end

    assign FRM_VLD   = (r_state == CMP);
    assign FRM_WORD  = (r_state == CMP) ? w_frame_word : r_frm_word;
    assign FRM_ABORT = r_frm_abort;

    // Shared pulse timer; a new hit reloads the width and adds its channels,
    // a miss leaves a running pulse alone. The vector is zero whenever the
    // counter is zero, so OR-ing it in is safe even when idle.
    always_ff @(posedge CLK160M) begin
        if (RESET) begin
            r_pls_cnt <= '0;
            r_pls_vec <= '0;
        end else if (|w_hit) begin
            r_pls_cnt <= pls_len(PLS_WIDTH);
            r_pls_vec <= r_pls_vec | w_hit;
        end else if (r_pls_cnt != '0) begin
            r_pls_cnt <= r_pls_cnt - PW_W'(1);
            if (r_pls_cnt == PW_W'(1)) r_pls_vec <= '0;
        end
    end

    assign TRG_PLS = r_pls_vec;

    // Saturating hit counters; clear wins over a same-cycle hit
    always_ff @(posedge CLK160M) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (RESET || CNT_CLR)  r_hit_cnt[i] <= '0;
            else if (w_hit[i])     r_hit_cnt[i] <= sat_inc(r_hit_cnt[i]);
        end
    end

endmodule

// File: tb/tb_ptmch_trg_multi.sv
// Randomised scoreboard bench for ptmch_trg_multi (built with CNT_W=4).
`timescale 1ns/1ps
module tb_ptmch_trg_multi;
    import ptmch_trg_pkg::*;

    localparam int NUM_CH = 8, OPC_W = 8, ADDR_W = 24, PW_W = 8, CNT_W = 4;
    localparam int FB = OPC_W + ADDR_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cs, sck, mosi, cnt_clr;
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH*OPC_W-1:0]  ch_opc_f, ch_mask_f;
    logic [NUM_CH*ADDR_W-1:0] ch_lo_f, ch_hi_f;
    logic [PW_W-1:0]          pw;
    logic [NUM_CH-1:0]        trg;
    logic [NUM_CH*CNT_W-1:0]  hit;
    logic                     frm_vld, frm_abort;
    logic [FB-1:0]            frm_word;

    logic [OPC_W-1:0]  c_opc [NUM_CH];
    logic [OPC_W-1:0]  c_mask[NUM_CH];
    logic [ADDR_W-1:0] c_lo  [NUM_CH];
    logic [ADDR_W-1:0] c_hi  [NUM_CH];
    logic [7:0]        opcs  [7];

    always_comb begin
        ch_opc_f = '0; ch_mask_f = '0; ch_lo_f = '0; ch_hi_f = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_opc_f[i*OPC_W +: OPC_W]    = c_opc[i];
            ch_mask_f[i*OPC_W +: OPC_W]   = c_mask[i];
            ch_lo_f[i*ADDR_W +: ADDR_W]   = c_lo[i];
            ch_hi_f[i*ADDR_W +: ADDR_W]   = c_hi[i];
        end
    end

    ptmch_trg_multi #(
        .NUM_CH(NUM_CH), .OPC_W(OPC_W), .ADDR_W(ADDR_W), .PW_W(PW_W), .CNT_W(CNT_W)
    ) dut (
        .CLK160M(clk), .RESET(rst), .SPI_CS(cs), .SPI_CLK(sck), .SPI_MOSI(mosi),
        .CH_EN(ch_en), .CH_OPC(ch_opc_f), .CH_OPC_MASK(ch_mask_f),
        .CH_LOW_ADDR(ch_lo_f), .CH_HIGH_ADDR(ch_hi_f), .PLS_WIDTH(pw),
        .CNT_CLR(cnt_clr), .TRG_PLS(trg), .HIT_CNT(hit), .FRM_VLD(frm_vld),
        .FRM_WORD(frm_word), .FRM_ABORT(frm_abort)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit                abort;
        int                cyc;
        logic [FB-1:0]     word;
        logic [NUM_CH-1:0] m;
    } exp_t;
    exp_t q[$];

    int n_tests = 0, n_fail = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference decision straight from the matching rules
    function automatic logic [NUM_CH-1:0] ref_match(input logic [FB-1:0] w);
        logic [NUM_CH-1:0] m;
        int unsigned opc, addr;
        m = '0;
        opc  = w[FB-1 -: OPC_W];
        addr = w[ADDR_W-1:0];
        for (int c = 0; c < NUM_CH; c++)
            if (ch_en[c] && ((opc ^ c_opc[c]) & c_mask[c]) == 0 &&
                c_lo[c] <= addr && addr <= c_hi[c])
                m[c] = 1'b1;
        return m;
    endfunction

    // Monitor: pops the scoreboard on each strobe and tracks expected pulses
    // as absolute end times and expected counters as plain integers.
    int pend = -1;
    logic [NUM_CH-1:0] pset = '0;
    int mcnt [NUM_CH];
    logic [FB-1:0] last_word = '0;

    initial begin
        exp_t e;
        bit got_frame;
        logic [NUM_CH-1:0] m;
        logic [NUM_CH*CNT_W-1:0] exp_hit;
        for (int c = 0; c < NUM_CH; c++) mcnt[c] = 0;
        forever begin
            @(negedge clk); #1;
            if (mon_on) begin
                got_frame = 1'b0;
                m = '0;
                if (frm_vld || frm_abort) begin
                    if (q.size() == 0) begin
                        chk("unexpected_strobe", {frm_vld, frm_abort}, 2'b00);
                    end else begin
                        e = q.pop_front();
                        chk(e.abort ? "abort_strobe" : "vld_strobe", {frm_vld, frm_abort},
                            e.abort ? 2'b01 : 2'b10);
                        chk("strobe_cycle", cyc, e.cyc);
                        if (!e.abort && frm_vld) begin
                            got_frame = 1'b1;
                            m = e.m;
                            last_word = e.word;
                        end
                    end
                end
                chk("frm_word", frm_word, last_word);
                chk("trg_pls", trg, (cyc <= pend) ? pset : '0);
                for (int c = 0; c < NUM_CH; c++) exp_hit[c*CNT_W +: CNT_W] = CNT_W'(mcnt[c]);
                chk("hit_cnt", hit, exp_hit);
                // Effects of the coming clock edge
                if (rst) begin
                    pend = -1;
                    pset = '0;
                    last_word = '0;
                    for (int c = 0; c < NUM_CH; c++) mcnt[c] = 0;
                end else begin
                    if (got_frame && m != '0) begin
                        pset = (cyc <= pend) ? (pset | m) : m;
                        pend = cyc + ((pw == 0) ? 1 : int'(pw));
                    end
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (cnt_clr) mcnt[c] = 0;
                        else if (got_frame && m[c] && mcnt[c] < CNT_MAX) mcnt[c]++;
                    end
                end
            end
        end
    end

    // Drive one SPI frame of nbits (full frame when nbits == FB), then
    // optional data-phase clocks, then CS high.
    task automatic send_frame(input logic [FB-1:0] w, input int nbits, input int extra,
                              input bit clr_hit, input int hh);
        int h;
        exp_t e;
        h = (hh == 0) ? $urandom_range(3, 5) : hh;
        @(negedge clk); cs = 1'b0;
        repeat (3) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            sck = 1'b0;
            mosi = w[FB-1-b];
            repeat (h) @(negedge clk);
            sck = 1'b1;
            if (b == FB - 1) begin
                e.abort = 1'b0; e.cyc = cyc + 3; e.word = w; e.m = ref_match(w);
                q.push_back(e);
                for (int k = 0; k < h; k++) begin
                    @(negedge clk);
                    cnt_clr = clr_hit && (cyc == e.cyc);
                end
                if (cnt_clr) begin @(negedge clk); cnt_clr = 1'b0; end
            end else begin
                repeat (h) @(negedge clk);
            end
        end
        sck = 1'b0;
        repeat (h) @(negedge clk);
        for (int x = 0; x < extra; x++) begin
            mosi = 1'($urandom);
            sck = 1'b1; repeat (h) @(negedge clk);
            sck = 1'b0; repeat (h) @(negedge clk);
        end
        cs = 1'b1;
        if (nbits < FB) begin
            e.abort = 1'b1; e.cyc = cyc + 3; e.word = '0; e.m = '0;
            q.push_back(e);
        end
        repeat ($urandom_range(4, 8)) @(negedge clk);
    endtask

    task automatic clear_cfg();
        for (int c = 0; c < NUM_CH; c++) begin
            c_opc[c] = '0; c_mask[c] = '0; c_lo[c] = '0; c_hi[c] = '0;
        end
        ch_en = '0;
    endtask

    task automatic rand_cfg();
        for (int c = 0; c < NUM_CH; c++) begin
            c_opc[c]  = opcs[$urandom_range(0, 6)];
            c_mask[c] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            c_lo[c]   = 24'($urandom);
            c_hi[c]   = ($urandom_range(0, 7) == 0) ? c_lo[c] - 24'd5
                                                    : c_lo[c] + 24'($urandom_range(0, 4096));
        end
        ch_en = NUM_CH'($urandom);
        pw = PW_W'($urandom_range(0, 30));
    endtask

    initial begin
        logic [FB-1:0] w;
        int c;
        opcs = '{PROGRAM_EXECUTE, READ_STATUS1, READ_STATUS2, BLOCK_ERASE_128K,
                 PAGE_DATA_READ, WRITE_STATUS1, WRITE_STATUS2};
        rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0; cnt_clr = 1'b0; pw = '0;
        clear_cfg();
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        @(negedge clk); rst = 1'b0;
        #2;
        chk("rst_trg", trg, '0);
        chk("rst_hit", hit, '0);
        chk("rst_vld", frm_vld, 1'b0);
        chk("rst_abort", frm_abort, 1'b0);
        chk("rst_word", frm_word, '0);

        // Basic hit on ch0; ch3 has an inverted window and must stay silent
        c_opc[0] = PROGRAM_EXECUTE; c_mask[0] = 8'hFF; c_lo[0] = 24'h000100; c_hi[0] = 24'h0001FF;
        c_opc[3] = 8'h00; c_mask[3] = 8'h00; c_lo[3] = 24'h000200; c_hi[3] = 24'h000100;
        ch_en = 8'b0000_1001;
        pw = 8'd16;
        send_frame(32'h10000150, FB, 2, 1'b0, 0);
        repeat (20) @(negedge clk);
        #2 chk("t1_hit0", hit[CNT_W-1:0], 1);
        chk("t1_hit3", hit[3*CNT_W +: CNT_W], 0);

        // Window boundaries
        send_frame(32'h100000FF, FB, 1, 1'b0, 0);
        send_frame(32'h10000200, FB, 0, 1'b0, 0);
        send_frame(32'h10000100, FB, 0, 1'b0, 0);
        repeat (20) @(negedge clk);
        send_frame(32'h100001FF, FB, 3, 1'b0, 0);
        repeat (20) @(negedge clk);

        // Masked opcode on ch1, then disabled
        c_opc[1] = READ_STATUS1; c_mask[1] = 8'hF0; c_lo[1] = 24'h0; c_hi[1] = 24'h000010;
        ch_en[1] = 1'b1;
        send_frame(32'h05000000, FB, 0, 1'b0, 0);
        repeat (20) @(negedge clk);
        ch_en[1] = 1'b0;
        send_frame(32'h05000000, FB, 0, 1'b0, 0);

        // Abort after 20 bits, then a full frame for ch2
        c_opc[2] = BLOCK_ERASE_128K; c_mask[2] = 8'hFF; c_lo[2] = 24'h0; c_hi[2] = 24'hFFFFFF;
        ch_en[2] = 1'b1;
        send_frame(32'hD8123456, 20, 0, 1'b0, 0);
        send_frame(32'hD8123456, FB, 0, 1'b0, 0);
        repeat (30) @(negedge clk);

        // Long pulse retriggered by a second hit, then a miss during the pulse,
        // then a zero width that becomes a single cycle
        pw = 8'd255;
        send_frame(32'h10000180, FB, 0, 1'b0, 3);
        send_frame(32'hD8000001, FB, 0, 1'b0, 3);
        send_frame(32'h13000000, FB, 0, 1'b0, 3);
        repeat (300) @(negedge clk);
        pw = 8'd0;
        send_frame(32'h10000101, FB, 0, 1'b0, 0);
        repeat (10) @(negedge clk);

        // Saturation of a 4-bit counter, then clear colliding with a hit
        ch_en = 8'b0000_0001;
        pw = 8'd2;
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        for (int i = 0; i < 17; i++)
            send_frame({PROGRAM_EXECUTE, 24'h000100 + 24'($urandom_range(0, 255))}, FB, 0, 1'b0, 3);
        #2 chk("sat_hit0", hit[CNT_W-1:0], CNT_MAX);
        send_frame(32'h10000111, FB, 0, 1'b1, 0);
        #2 chk("clr_prio_hit0", hit[CNT_W-1:0], 0);

        // Reset while a pulse is running
        pw = 8'd200;
        send_frame(32'h10000122, FB, 0, 1'b0, 0);
        #2 chk("pulse_before_rst", trg[0], 1'b1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #2 chk("trg_after_rst", trg, '0);
        chk("hit_after_rst", hit, '0);
        send_frame(32'h10000133, FB, 0, 1'b0, 0);
        repeat (220) @(negedge clk);

        // Randomised traffic
        for (int blk = 0; blk < 5; blk++) begin
            rand_cfg();
            for (int i = 0; i < 5; i++) begin
                c = $urandom_range(0, NUM_CH - 1);
                w[FB-1 -: OPC_W] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : c_opc[c];
                w[ADDR_W-1:0]    = c_lo[c] + 24'($urandom_range(0, 4200)) - 24'd50;
                if ($urandom_range(0, 4) == 0)
                    send_frame(w, $urandom_range(1, FB - 1), 0, 1'b0, 0);
                else
                    send_frame(w, FB, $urandom_range(0, 3), 1'b0, 0);
                repeat ($urandom_range(0, 40)) @(negedge clk);
            end
        end

        repeat (60) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
